// File: rtl/seg_disp_pkg.sv
// Shared constants and helpers for the four-digit multiplexed 7-segment scan controller.
package seg_disp_pkg;

  localparam int NUM_DIGITS          = 4;
  localparam int DIGIT_W             = 4;
  localparam int IDX_W               = $clog2(NUM_DIGITS);
  localparam int REFRESH_DIV_DEFAULT = 100000;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

  typedef logic [NUM_DIGITS*DIGIT_W-1:0] bcd_word_t;
  typedef logic [IDX_W-1:0]              digit_idx_t;

  // Active-low one-hot anode pattern for the given digit slot.
  function automatic logic [NUM_DIGITS-1:0] anode_sel(input digit_idx_t idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg_scan_mux_tick.sv
// Refresh prescaler: free-running 0..REFRESH_DIV-1 counter with a 1-cycle tick on the last count.
module scan_tick_gen
  import seg_disp_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int               CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_MAX);

  // NOTE: combinational next-state blocks assign every output on every path so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick_o) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit scan controller with frame-boundary double buffering.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg_scan_mux
  import seg_disp_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           digits_in,
  input  logic                  load,
  output logic                  pending,
  output logic [DIGIT_W-1:0]    bcd_out,
  output logic [NUM_DIGITS-1:0] an_out,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_tick
);

  logic       tick, boundary;
  digit_idx_t idx_q, idx_d, didx_q;
  bcd_word_t  stage_q, stage_d, active_q, active_d;
  logic       pending_q, pending_d;
  logic [DIGIT_W-1:0]    bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] an_q, an_d, blank;

  scan_tick_gen #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  assign boundary = tick && (idx_q == digit_idx_t'(NUM_DIGITS - 1));

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every digit above it are zero; digit 0 is never blanked.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank      = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (active_q[i*DIGIT_W +: DIGIT_W] == '0);
      blank[i]   = zero_above;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    idx_d     = tick ? idx_q + digit_idx_t'(1) : idx_q;
    stage_d   = stage_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (boundary) begin
      // A load landing on the boundary goes straight to the display and supersedes any staged word.
      if (load)           active_d = digits_in;
      else if (pending_q) active_d = stage_q;
      pending_d = 1'b0;
    end else if (load) begin
      stage_d   = digits_in;
      pending_d = 1'b1;
    end
    bcd_d = active_q[DIGIT_W*idx_q +: DIGIT_W];
    an_d  = blank[idx_q] ? ANODE_OFF : anode_sel(idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      stage_q   <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      bcd_q     <= '0;
      an_q      <= ANODE_OFF;
      didx_q    <= '0;
    end else begin
      idx_q     <= idx_d;
      stage_q   <= stage_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      bcd_q     <= bcd_d;
      an_q      <= an_d;
      didx_q    <= idx_q;
    end
  end

  assign pending    = pending_q;
  assign bcd_out    = bcd_q;
  assign an_out     = an_q;
  assign digit_idx  = didx_q;
  assign frame_tick = boundary;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with REFRESH_DIV=4 (16-cycle frames); tracks LEADING_ZERO_BLANK_EN.
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] digits_in = '0;
  logic        load = 1'b0;
  logic        pending, frame_tick;
  logic [3:0]  bcd_out, an_out;
  logic [1:0]  digit_idx;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] BLANK_0000 = 4'b1110;
  localparam logic [3:0] BLANK_0050 = 4'b1100;
`else
  localparam logic [3:0] BLANK_0000 = 4'b0000;
  localparam logic [3:0] BLANK_0050 = 4'b0000;
`endif

  seg_scan_mux #(.REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .load       (load),
    .pending    (pending),
    .bcd_out    (bcd_out),
    .an_out     (an_out),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_load(input logic [15:0] word);
    digits_in = word;
    load      = 1'b1;
    step();
    load      = 1'b0;
  endtask

  // Advance until a frame_tick sample, bounded so a dead scan cannot hang the run.
  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = frame_tick;
    end
    check("frame_tick_seen", 32'(seen), 32'd1);
  endtask

  // Called one sample after the boundary; checks each slot's first cycle of the new frame.
  task automatic check_frame(input string tag, input logic [15:0] word, input logic [3:0] blank);
    logic [3:0] exp_an;
    for (int s = 0; s < 4; s++) begin
      step();
      exp_an = blank[s] ? 4'b1111 : ~(4'b0001 << s);
      check($sformatf("%s_an%0d", tag, s), 32'(an_out), 32'(exp_an));
      check($sformatf("%s_bcd%0d", tag, s), 32'(bcd_out), 32'(word[4*s +: 4]));
      check($sformatf("%s_idx%0d", tag, s), 32'(digit_idx), s);
      repeat (3) step();
    end
  endtask

  initial begin
    int pulses;
    logic [3:0] exp_an;

    // 1: reset values, scan sequence, frame_tick period
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an_out), 32'h0000_000f);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_idx", 32'(digit_idx), 32'd0);
    check("rst_ftick", 32'(frame_tick), 32'd0);
    rst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      step();
      exp_an = BLANK_0000[(c-1)/4] ? 4'b1111 : ~(4'b0001 << ((c-1)/4));
      check($sformatf("scan_an_c%0d", c), 32'(an_out), 32'(exp_an));
      check($sformatf("scan_ftick_c%0d", c), 32'(frame_tick), (c == 15) ? 32'd1 : 32'd0);
    end
    pulses = 0;
    repeat (48) begin
      step();
      if (frame_tick) pulses++;
    end
    check("ftick_per_48", pulses, 3);

    // 2: load mid-frame, staged until boundary
    wait_frame();
    repeat (5) step();
    pulse_load(16'h1234);
    check("t2_pending_set", 32'(pending), 32'd1);
    wait_frame();
    check("t2_pending_at_tick", 32'(pending), 32'd1);
    step();
    check("t2_pending_clr", 32'(pending), 32'd0);
    check_frame("t2", 16'h1234, 4'b0000);

    // 3: load in the boundary cycle itself
    wait_frame();
    check("t3_pending_before", 32'(pending), 32'd0);
    pulse_load(16'h5678);
    check("t3_pending_never", 32'(pending), 32'd0);
    check_frame("t3", 16'h5678, 4'b0000);

    // 4: last load before the boundary wins
    repeat (2) step();
    pulse_load(16'h1111);
    repeat (2) step();
    pulse_load(16'h2222);
    check("t4_pending", 32'(pending), 32'd1);
    wait_frame();
    step();
    check_frame("t4", 16'h2222, 4'b0000);

    // 5: leading zero blanking (or none, macro off)
    pulse_load(16'h0050);
    wait_frame();
    step();
    check_frame("t5", 16'h0050, BLANK_0050);

    // 6: async reset mid-frame with a staged word
    wait_frame();
    repeat (3) step();
    pulse_load(16'h9999);
    check("t6_pending", 32'(pending), 32'd1);
    repeat (2) step();
    #2 rst = 1'b1;
    #1;
    check("t6_rst_an", 32'(an_out), 32'h0000_000f);
    check("t6_rst_bcd", 32'(bcd_out), 32'd0);
    check("t6_rst_pending", 32'(pending), 32'd0);
    check("t6_rst_idx", 32'(digit_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("t6_first_an", 32'(an_out), 32'h0000_000e);
    check("t6_first_bcd", 32'(bcd_out), 32'd0);
    wait_frame();
    step();
    check("t6_pending_after", 32'(pending), 32'd0);
    check_frame("t6", 16'h0000, BLANK_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
